// File: rtl/avmm_pio_gen2_pkg.sv
// Shared constants for the Avalon-MM PIO: register map, edge-type encodings
// and the bit layout of the read-only PARAM word.
package avmm_pio_gen2_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
    localparam logic [2:0] ADDR_OUTSET   = 3'd3;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd4;
    localparam logic [2:0] ADDR_PARAM    = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // PARAM word: {DEBOUNCE_CYC[15:0], EDGE_TYPE[1:0], 8'b0, DATA_W[5:0]}
    localparam int PARAM_DEB_LSB   = 16;
    localparam int PARAM_DEB_W     = 16;
    localparam int PARAM_EDGE_LSB  = 14;
    localparam int PARAM_EDGE_W    = 2;
    localparam int PARAM_WIDTH_LSB = 0;
    localparam int PARAM_WIDTH_W   = 6;

    function automatic logic [31:0] param_word(input int deb_cyc, input int edge_type,
                                               input int width);
        logic [31:0] w;
        w = '0;
        w[PARAM_DEB_LSB   +: PARAM_DEB_W]   = deb_cyc[PARAM_DEB_W-1:0];
        w[PARAM_EDGE_LSB  +: PARAM_EDGE_W]  = edge_type[PARAM_EDGE_W-1:0];
        w[PARAM_WIDTH_LSB +: PARAM_WIDTH_W] = width[PARAM_WIDTH_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/avmm_pio_gen2_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
// With DEBOUNCE_CYC=0 the synchroniser output is used directly.
module pio_debounce #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic deb
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic sync_p0;
    logic sync_p1;

    // Metastability guard for the asynchronous pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

    if (DEBOUNCE_CYC == 0) begin : g_bypass
        assign deb = sync_p1;
    end else begin : g_filter
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

        logic [CNT_W-1:0] cnt;
        logic             deb_p2;

        // Accept the synchronised value only after it has differed for DEBOUNCE_CYC cycles
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                deb_p2 <= 1'b0;
            end else if (sync_p1 == deb_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                deb_p2 <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign deb = deb_p2;
    end

endmodule

// File: rtl/avmm_pio_gen2.sv
// Avalon-MM PIO: debounced inputs with edge capture and level interrupt,
// plus an output register with set/clear aliases. Fixed 1-cycle read latency.
module avmm_pio_gen2
    import avmm_pio_gen2_pkg::*;
#(
    parameter int                DATA_W       = 10,
    parameter int                DEBOUNCE_CYC = 16,
    parameter int                EDGE_TYPE    = 0,
    parameter logic [DATA_W-1:0] OUT_RESET    = '0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [DATA_W-1:0] in_export,
    output logic [DATA_W-1:0] out_export,
    output logic              irq
);

    logic [DATA_W-1:0] deb_p2;
    logic [DATA_W-1:0] deb_prev_p3;
    logic [DATA_W-1:0] edge_hit;
    logic [DATA_W-1:0] edge_cap;
    logic [DATA_W-1:0] irq_mask;
    logic [DATA_W-1:0] out_reg;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       rd_word;
    logic              wr_data;
    logic              wr_mask;
    logic              wr_w1c;
    logic              wr_set;
    logic              wr_clr;
    logic              rd_go;

    assign wdata = avs_writedata[DATA_W-1:0];

    if (DATA_W < 32) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^avs_writedata[31:DATA_W];
    end

    assign wr_data = avs_write && (avs_address == ADDR_DATA);
    assign wr_mask = avs_write && (avs_address == ADDR_IRQ_MASK);
    assign wr_w1c  = avs_write && (avs_address == ADDR_EDGE_CAP);
    assign wr_set  = avs_write && (avs_address == ADDR_OUTSET);
    assign wr_clr  = avs_write && (avs_address == ADDR_OUTCLR);
    // A read that collides with a write is dropped so the bus sees only the write
    assign rd_go   = avs_read && !avs_write;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        pio_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk  (clk_clk),
            .rst_n(reset_reset_n),
            .pin  (in_export[i]),
            .deb  (deb_p2[i])
        );
    end

    // Edge detector on the debounced inputs, selected by EDGE_TYPE
    always_comb begin
        edge_hit = deb_p2 & ~deb_prev_p3;
        if (EDGE_TYPE == int'(EDGE_FALL)) begin
            edge_hit = ~deb_p2 & deb_prev_p3;
        end else if (EDGE_TYPE == int'(EDGE_ANY)) begin
            edge_hit = deb_p2 ^ deb_prev_p3;
        end
    end

    // Register read multiplexer; unused addresses and upper bits read as zero
    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA:     rd_word[DATA_W-1:0] = deb_p2;
            ADDR_IRQ_MASK: rd_word[DATA_W-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_word[DATA_W-1:0] = edge_cap;
            ADDR_PARAM:    rd_word = param_word(DEBOUNCE_CYC, EDGE_TYPE, DATA_W);
            default:       rd_word = '0;
        endcase
    end

    // Edge capture (new edge wins over a same-cycle clear), mask and interrupt
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            deb_prev_p3 <= '0;
            edge_cap    <= '0;
            irq_mask    <= '0;
            irq         <= 1'b0;
        end else begin
            deb_prev_p3 <= deb_p2;
            edge_cap    <= (edge_cap & ~({DATA_W{wr_w1c}} & wdata)) | edge_hit;
            if (wr_mask) begin
                irq_mask <= wdata;
            end
            irq <= |(edge_cap & irq_mask);
        end
    end

    // Output register with direct load, set-alias and clear-alias
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            out_reg <= OUT_RESET;
        end else if (wr_data) begin
            out_reg <= wdata;
        end else if (wr_set) begin
            out_reg <= out_reg | wdata;
        end else if (wr_clr) begin
            out_reg <= out_reg & ~wdata;
        end
    end

    assign out_export = out_reg;

    // Read response, one cycle after the accepted read strobe
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= rd_go;
            if (rd_go) begin
                avs_readdata <= rd_word;
            end
        end
    end

endmodule

// File: doc/avmm_pio_gen2.md
AVMM_PIO_GEN2 -- requirements
Module: avmm_pio_gen2

Interface
REQ-001 SHALL have parameter DATA_W, default 10: channel count (bits), legal range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 16: stable cycles required per input bit; 0 bypasses debounce.
REQ-003 SHALL have parameter EDGE_TYPE, default 0: 0 rising, 1 falling, 2 any edge.
REQ-004 SHALL have parameter OUT_RESET, default 0: output register reset value, DATA_W bits.
REQ-005 SHALL have port clk_clk, input, 1: sole clock. All logic runs on this one clock.
REQ-006 SHALL have port reset_reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port avs_address, input, 3: word address.
REQ-008 SHALL have ports avs_read and avs_write, input, 1 each: Avalon-MM strobes.
REQ-009 SHALL have port avs_writedata, input, 32, and port avs_readdata, output, 32.
REQ-010 SHALL have port avs_readdatavalid, output, 1.
REQ-011 SHALL have port in_export, input, DATA_W: asynchronous pins (buttons/switches).
REQ-012 SHALL have port out_export, output, DATA_W: output register (LEDs).
REQ-013 SHALL have port irq, output, 1: active-high level interrupt.

Function
REQ-014 SHALL synchronise in_export through 2 flip-flops per bit before any other use.
REQ-015 SHALL, per bit, keep a debounced value and a counter. The counter clears whenever the synchronised value equals the debounced value. Otherwise it increments. When the counter reaches DEBOUNCE_CYC-1, the debounced value updates and the counter clears.
REQ-016 SHALL make the debounced bit change exactly 2+DEBOUNCE_CYC cycles after a stable pin change. With DEBOUNCE_CYC=0 this is 2 cycles.
REQ-017 SHALL set edge_cap[i] the cycle after debounced[i] shows an edge matching EDGE_TYPE.
REQ-018 SHALL decode registers:
  - 0 DATA: read returns the debounced inputs; write loads out_reg.
  - 1 IRQ_MASK: read/write.
  - 2 EDGE_CAP: read; write-1-to-clear.
  - 3 OUTSET: write, out_reg |= wdata.
  - 4 OUTCLR: write, out_reg &= ~wdata.
  - 5 PARAM: read only; returns {DEBOUNCE_CYC[15:0], EDGE_TYPE[1:0], 8'b0, DATA_W[5:0]}.
  - 6 and 7: reads return 0; writes are ignored.
REQ-019 SHALL return avs_readdata with avs_readdatavalid exactly 1 cycle after avs_read, without stalls. Bits above DATA_W read as zero.
REQ-020 SHALL take writes effect on the clock edge where avs_write is high. Writedata bits above DATA_W are ignored.
REQ-021 SHALL give a new edge priority over a simultaneous W1C of the same bit: the bit stays set.
REQ-022 SHALL treat simultaneous avs_read and avs_write as a write only: no readdatavalid is generated.
REQ-023 SHALL drive irq as a registered OR of (edge_cap & irq_mask). irq asserts 1 cycle after edge_cap sets and deasserts 1 cycle after the clear.
REQ-024 SHALL drive out_export directly from out_reg, with 0 cycles of extra latency.

Reset
REQ-025 SHALL, while reset_reset_n is low, asynchronously force:
  - synchronisers, debounced values and counters to 0;
  - edge_cap and irq_mask to 0;
  - out_reg to OUT_RESET;
  - avs_readdata, avs_readdatavalid and irq to 0.
REQ-026 SHALL not generate spurious edges after reset release, since debounced starts at 0. A pin already high at release therefore yields one rising edge after debounce, which is the intended behaviour.
REQ-027 SHALL discard any transaction in flight when reset asserts mid-read: no readdatavalid follows.

Structure
REQ-028 SHALL place register address constants, the EDGE_TYPE encodings and the PARAM field layout in package avmm_pio_gen2_pkg.
REQ-029 SHALL implement the per-bit synchroniser and debounce as sub-module pio_debounce, instantiated DATA_W times with a generate loop.

Verification
REQ-030 SHALL check: with DEBOUNCE_CYC=4, hold in_export[0] at 1 for 3 cycles and then drop it -> DATA never changes and edge_cap stays 0.
REQ-031 SHALL check: with DEBOUNCE_CYC=4, IRQ_MASK=1 and in_export[0] held at 1 -> DATA[0]=1 at cycle 6, edge_cap[0]=1 at cycle 7, irq=1 at cycle 8.
REQ-032 SHALL check: write 0x3FF to DATA, then 0x005 to OUTCLR, then 0x400 to OUTSET (DATA_W=10) -> out_export=0x3FA.
REQ-033 SHALL check: W1C of edge_cap bit 2 in the same cycle as a new edge on bit 2 -> reading EDGE_CAP returns 0x004.
REQ-034 SHALL check: read PARAM with the default parameters -> readdata=0x0010000A, with readdatavalid exactly 1 cycle after read.
REQ-035 SHALL check: assert reset_reset_n low mid-read with out_reg=0x155 and OUT_RESET=0x2AA -> out_export=0x2AA immediately, no readdatavalid, irq=0.
